// File: rtl/pow_n_seq.sv
// rtl/pow_n_seq.sv - sequential n^exp by MSB-first square-and-multiply, one exponent bit per cycle
module pow_n_seq #(
    parameter int WIDTH     = 18,
    parameter int EXP_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [WIDTH-1:0]     n,
    input  logic [EXP_WIDTH-1:0] exp,
    output logic                 busy,
    output logic                 ready,
    output logic [WIDTH-1:0]     n_pow,
    output logic                 overflow
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     base_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [IW-1:0]        idx_q;
    logic [WIDTH-1:0]     acc_q;
    logic                 ovf_q;
    logic [WIDTH-1:0]     n_pow_q;
    logic                 overflow_q;
    logic                 ready_q;
    logic                 busy_q;

    logic [PW-1:0]        sq_full;
    logic [PW-1:0]        mul_full;
    logic                 bit_set;
    logic [WIDTH-1:0]     acc_d;
    logic                 ovf_d;

    // Once acc has not yet overflowed it equals the true partial power, so any
    // high bit in either full-precision product means the true result overflows.
    always_comb begin
        sq_full  = PW'(acc_q) * PW'(acc_q);
        mul_full = PW'(sq_full[WIDTH-1:0]) * PW'(base_q);
        bit_set  = exp_q[idx_q];
        acc_d    = bit_set ? mul_full[WIDTH-1:0] : sq_full[WIDTH-1:0];
        ovf_d    = ovf_q | (|sq_full[PW-1:WIDTH]) | (bit_set & (|mul_full[PW-1:WIDTH]));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            exp_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            n_pow_q    <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                CALC: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    idx_q <= idx_q - IW'(1);
                    if (idx_q == '0) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        n_pow_q    <= acc_d;
                        overflow_q <= ovf_d;
                        ready_q    <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, allowing back-to-back runs
                    if (run) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        base_q  <= n;
                        exp_q   <= exp;
                        idx_q   <= IW'(EXP_WIDTH - 1);
                        acc_q   <= WIDTH'(1);
                        ovf_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign n_pow    = n_pow_q;
    assign overflow = overflow_q;

endmodule
